// File: rtl/top_level.sv
//------------------------------------------------------------------------------
// Module  : top_level
// Brief   : Hamming(16,11) SECDED encoder over an internal byte memory (dm1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);
    logic [7:0] core [0:DEPTH-1];

    assign o_rdata = core[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            core[i_waddr] <= i_wdata;
        end
    end
endmodule

module top_level #(
    parameter int NUM_MSG   = 15,
    parameter int OUT_BASE  = 30,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [3:0]        c_last     = 4'(NUM_MSG - 1);
    localparam logic [ADDR_W-1:0] c_out_base = ADDR_W'(OUT_BASE);

    logic [2:0] r_state;
    logic [3:0] r_idx;
    logic [7:0] r_lo;
    logic [2:0] r_hi;
    logic       r_done;

    logic [11:1]       w_d;
    logic              w_p8, w_p4, w_p2, w_p1, w_p0;
    logic [15:0]       w_word;
    logic [ADDR_W-1:0] w_msg_base;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_rdata;
    logic [7:0]        w_wdata;
    logic              w_we;
    logic              w_unused;

    assign w_d  = {r_hi, r_lo};
    assign w_p8 = ^w_d[11:5];
    assign w_p4 = (^w_d[11:8]) ^ (^w_d[4:2]);
    assign w_p2 = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
    assign w_p1 = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
    assign w_p0 = (^w_d[11:1]) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;

    assign w_word = {w_d[11:5], w_p8, w_d[4:2], w_p4, w_d[1], w_p2, w_p1, w_p0};

    // Message i occupies bytes 2i/2i+1 on input and OUT_BASE+2i/+2i+1 on output.
    assign w_msg_base = {{(ADDR_W-5){1'b0}}, r_idx, 1'b0};
    assign w_raddr    = w_msg_base | {{(ADDR_W-1){1'b0}}, (r_state == S_RD_HI)};
    assign w_waddr    = w_msg_base + c_out_base + {{(ADDR_W-1){1'b0}}, (r_state == S_WR_HI)};
    assign w_we       = (r_state == S_WR_LO) || (r_state == S_WR_HI);
    assign w_wdata    = (r_state == S_WR_HI) ? w_word[15:8] : w_word[7:0];

    // Upper five bits of the high input byte carry no message data.
    assign w_unused = ^w_rdata[7:3];

    data_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) dm1 (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_lo    <= 8'd0;
            r_hi    <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_done  <= 1'b0;
                        r_idx   <= 4'd0;
                        r_state <= S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    r_lo    <= w_rdata;
                    r_state <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_hi    <= w_rdata[2:0];
                    r_state <= S_WR_LO;
                end
                S_WR_LO: begin
                    r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (r_idx == c_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= S_RD_LO;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done = r_done;
endmodule

`default_nettype wire

// File: tb/tb_top_level.sv
//------------------------------------------------------------------------------
// Module  : tb_top_level
// Brief   : Self-checking bench for top_level (backdoor memory load/check).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_top_level;
    logic clk;
    logic reset;
    logic req;
    logic done;

    int checks;
    int failures;

    typedef struct {
        logic [10:0] d;
        logic [4:0]  junk;
        logic [15:0] w;
    } vec_t;

    vec_t       tbl  [15];
    vec_t       tbl2 [15];
    logic [7:0] snap [0:29];

    top_level #(
        .NUM_MSG   (15),
        .OUT_BASE  (30),
        .MEM_DEPTH (256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Positional Hamming model: parity k covers codeword positions with bit k set.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic        p;
        w       = 16'h0000;
        w[3]    = d[0];
        w[5]    = d[1];
        w[6]    = d[2];
        w[7]    = d[3];
        w[15:9] = d[10:4];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j < 16; j++) begin
                if (((j >> k) & 1) == 1) p = p ^ w[j];
            end
            w[1 << k] = p;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit second);
        vec_t v;
        for (int i = 0; i < 15; i++) begin
            v = second ? tbl2[i] : tbl[i];
            dut.dm1.core[2*i]   = v.d[7:0];
            dut.dm1.core[2*i+1] = {v.junk, v.d[10:8]};
        end
        for (int a = 30; a < 256; a++) dut.dm1.core[a] = 8'hEE;
        for (int a = 0; a < 30; a++) snap[a] = dut.dm1.core[a];
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    // Returns the number of edges after the req edge at which done was first seen.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic check_outputs(input bit second, input string tag);
        vec_t v;
        for (int i = 0; i < 15; i++) begin
            v = second ? tbl2[i] : tbl[i];
            chk($sformatf("%s_lo%0d", tag, i), int'(dut.dm1.core[30+2*i]), int'(v.w[7:0]));
            chk($sformatf("%s_hi%0d", tag, i), int'(dut.dm1.core[31+2*i]), int'(v.w[15:8]));
        end
    endtask

    task automatic check_regions(input string tag);
        int bad_in;
        int bad_top;
        bad_in  = 0;
        bad_top = 0;
        for (int a = 0; a < 30; a++)    if (dut.dm1.core[a] !== snap[a]) bad_in++;
        for (int a = 60; a < 256; a++)  if (dut.dm1.core[a] !== 8'hEE)   bad_top++;
        chk({tag, "_inputs_kept"}, bad_in, 0);
        chk({tag, "_upper_kept"}, bad_top, 0);
    endtask

    initial begin
        int edges;
        checks   = 0;
        failures = 0;
        req      = 1'b0;
        reset    = 1'b0;

        tbl[0] = '{d: 11'h000, junk: 5'h00, w: 16'h0000};
        tbl[1] = '{d: 11'h7FF, junk: 5'h00, w: 16'hFFFF};
        tbl[2] = '{d: 11'h001, junk: 5'h00, w: 16'h000F};
        tbl[3] = '{d: 11'h400, junk: 5'h1F, w: 16'h8117};
        for (int i = 4; i < 15; i++) begin
            tbl[i].d    = 11'($urandom_range(0, 2047));
            tbl[i].junk = 5'($urandom_range(0, 31));
            tbl[i].w    = encode(tbl[i].d);
        end
        for (int i = 0; i < 15; i++) begin
            tbl2[i].d    = tbl[i].d ^ 11'h555;
            tbl2[i].junk = ~tbl[i].junk;
            tbl2[i].w    = encode(tbl2[i].d);
        end

        repeat (3) tick();
        chk("reset_done", int'(done), 0);
        load(1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("idle_done", int'(done), 0);

        // Run 1: full pass with a single-cycle request
        pulse_req();
        wait_done(edges);
        chk("run1_latency", edges, 61);
        check_outputs(1'b0, "run1");
        check_regions("run1");
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("done_hold%0d", c), int'(done), 1);
        end

        // Run 2: reset in the middle of message 7, then a clean rerun
        load(1'b1);
        pulse_req();
        for (int k = 0; k < 29; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_done", int'(done), 0);
        chk("kept_msg6_lo", int'(dut.dm1.core[42]), int'(tbl2[6].w[7:0]));
        chk("kept_msg6_hi", int'(dut.dm1.core[43]), int'(tbl2[6].w[15:8]));
        chk("unwritten_msg7", int'(dut.dm1.core[44]), 8'hEE);
        @(negedge clk);
        reset = 1'b1;
        edges = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (done) edges++;
        end
        chk("no_run_after_reset", edges, 0);
        chk("msg8_untouched", int'(dut.dm1.core[46]), 8'hEE);

        pulse_req();
        wait_done(edges);
        chk("run2_latency", edges, 61);
        check_outputs(1'b1, "run2");
        check_regions("run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
